// File: rtl/rv32_mdu_iter_if.sv
// Handshake bundle between the core and the iterative M-extension unit.
//   in_valid/in_ready : request handshake (op, rs1, rs2 qualify the request)
//   kill              : flush, aborts whatever the unit is doing
//   out_valid/out_ready : result handshake, result stable while out_valid
// master = core side, slave = the MDU.
interface rv32_mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, rs1, rs2, kill, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, rs1, rs2, kill, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/rv32_mdu_iter.sv
// Iterative M-extension unit: MUL/MULH/MULHSU/MULHU by shift-add and
// DIV/DIVU/REM/REMU by restoring division, BITS_PER_CYCLE bits per cycle.
// Operands are converted to magnitudes on accept; sign correction is applied
// once when the result is latched.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rv32_mdu_iter_if.slave (in_valid/in_ready, op, rs1, rs2, kill,
//          out_valid/out_ready, result)
module rv32_mdu_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  rv32_mdu_iter_if.slave bus
);

  localparam int N_ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam logic [CW-1:0] N_ITER_C = CW'(N_ITER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement negate when requested. An XLEN-bit unsigned magnitude
  // represents |MIN_INT| exactly, so no extra bit is needed here.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    cond_neg = neg ? (ZERO_X - v) : v;
  endfunction

  state_e            state_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        op_r;
  logic              neg_a_r;
  logic              neg_b_r;
  logic [2*XLEN-1:0] acc_r;   // product accumulator / remainder in [XLEN:0]
  logic [2*XLEN-1:0] b_r;     // shifting multiplicand / divisor in [XLEN-1:0]
  logic [XLEN-1:0]   a_r;     // multiplier / dividend becoming quotient
  logic              in_ready_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   result_r;

  logic              neg_a_s;
  logic              neg_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              fast_s;
  logic [XLEN-1:0]   fast_res_s;

  // Accept-time decode: signedness, magnitudes and the fast-path cases.
  always_comb begin
    logic sgn_a;
    logic sgn_b;
    logic div_zero;
    logic ovf;
    sgn_a = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
            (bus.op == OP_DIV)  || (bus.op == OP_REM);
    sgn_b = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    neg_a_s = sgn_a & bus.rs1[XLEN-1];
    neg_b_s = sgn_b & bus.rs2[XLEN-1];
    mag_a_s = cond_neg(bus.rs1, neg_a_s);
    mag_b_s = cond_neg(bus.rs2, neg_b_s);
    div_zero = bus.op[2] && (bus.rs2 == ZERO_X);
    ovf = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
          (bus.rs1 == MIN_INT) && (bus.rs2 == ALL_ONES);
    fast_s = div_zero || ovf;
    // op[1] separates REM/REMU from DIV/DIVU in the divide group.
    if (div_zero) begin
      fast_res_s = bus.op[1] ? bus.rs1 : ALL_ONES;
    end else begin
      fast_res_s = bus.op[1] ? ZERO_X : MIN_INT;
    end
  end

  logic [2*XLEN-1:0] acc_s;
  logic [2*XLEN-1:0] b_s;
  logic [XLEN-1:0]   a_s;

  // One CALC cycle worth of shift-add or restoring-divide steps.
  always_comb begin
    logic [XLEN:0] trial;
    acc_s = acc_r;
    b_s   = b_r;
    a_s   = a_r;
    trial = {(XLEN+1){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!op_r[2]) begin
        if (a_s[0]) begin
          acc_s = acc_s + b_s;
        end else begin
          acc_s = acc_s;
        end
        b_s = b_s << 1;
        a_s = a_s >> 1;
      end else begin
        // Bring the next dividend bit into the partial remainder.
        trial = {acc_s[XLEN-1:0], a_s[XLEN-1]};
        a_s   = a_s << 1;
        if (trial >= {1'b0, b_s[XLEN-1:0]}) begin
          acc_s[XLEN:0] = trial - {1'b0, b_s[XLEN-1:0]};
          a_s[0]        = 1'b1;
        end else begin
          acc_s[XLEN:0] = trial;
        end
      end
    end
  end

  logic [XLEN-1:0] final_s;

  // Result selection with sign correction, evaluated on the last CALC step.
  always_comb begin
    logic [2*XLEN-1:0] prod;
    prod = (neg_a_r ^ neg_b_r) ? ({(2*XLEN){1'b0}} - acc_s) : acc_s;
    case (op_r)
      OP_MUL:                       final_s = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_s = cond_neg(a_s, neg_a_r ^ neg_b_r);
      OP_REM, OP_REMU:              final_s = cond_neg(acc_s[XLEN-1:0], neg_a_r);
      default:                      final_s = prod[XLEN-1:0];
    endcase
  end

  // Control FSM and datapath registers; priority rst > kill > handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      op_r        <= 3'd0;
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
      acc_r       <= {(2*XLEN){1'b0}};
      b_r         <= {(2*XLEN){1'b0}};
      a_r         <= ZERO_X;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= ZERO_X;
    end else if (bus.kill) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            op_r       <= bus.op;
            neg_a_r    <= neg_a_s;
            neg_b_r    <= neg_b_s;
            acc_r      <= {(2*XLEN){1'b0}};
            in_ready_r <= 1'b0;
            // Multiply shifts the multiplicand left through b_r and consumes
            // the multiplier from a_r; divide keeps the divisor fixed in b_r
            // and shifts the dividend out of a_r.
            if (bus.op[2]) begin
              b_r <= {ZERO_X, mag_b_s};
              a_r <= mag_a_s;
            end else begin
              b_r <= {ZERO_X, mag_a_s};
              a_r <= mag_b_s;
            end
            if (fast_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= fast_res_s;
              cnt_r       <= {CW{1'b0}};
            end else begin
              state_r <= CALC;
              cnt_r   <= N_ITER_C;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_s;
          b_r   <= b_s;
          a_r   <= a_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= final_s;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_rv32_mdu_iter.sv
// Scoreboard bench for rv32_mdu_iter: the driver pushes the reference result,
// expected latency and accept cycle; an independent monitor pops and checks
// whenever out_valid appears, and checks result stability under backpressure.
module tb_rv32_mdu_iter;
  parameter int BPC = 1;
  localparam int XLEN   = 32;
  localparam int N_ITER = XLEN / BPC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32_mdu_iter_if #(.XLEN(XLEN)) bus_if ();

  rv32_mdu_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int bp_mode     = 0;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];
  int          acc_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    t  = 64'd0;
    case (op)
      3'd0: t = {32'd0, a} * {32'd0, b};
      3'd1: begin t = sa * sb; t = {32'd0, t[63:32]}; end
      3'd2: begin t = sa * ub; t = {32'd0, t[63:32]}; end
      3'd3: begin t = {32'd0, a} * {32'd0, b}; t = {32'd0, t[63:32]}; end
      3'd4: if (b == 32'd0) t = 64'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = 64'h8000_0000;
            else t = sa / sb;
      3'd5: t = (b == 32'd0) ? 64'hFFFF_FFFF : {32'd0, a / b};
      3'd6: if (b == 32'd0) t = {32'd0, a};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = 64'd0;
            else t = sa % sb;
      default: t = (b == 32'd0) ? {32'd0, a} : {32'd0, a % b};
    endcase
    return t[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return N_ITER + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; accept happens at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    int n;
    n = 0;
    while (!bus_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.in_ready) begin
      check("in_ready_timeout", {31'd0, bus_if.in_ready}, 32'd1);
    end else begin
      bus_if.op       = op;
      bus_if.rs1      = a;
      bus_if.rs2      = b;
      bus_if.in_valid = 1'b1;
      if (track) begin
        exp_res_q.push_back(ref_model(op, a, b));
        exp_lat_q.push_back(ref_latency(op, a, b));
        acc_cyc_q.push_back(cyc + 1);
      end
      @(negedge clk);
      bus_if.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_res_q.size() != 0 || bus_if.out_valid || !bus_if.in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: pending=%0d out_valid=%0b in_ready=%0b",
               exp_res_q.size(), bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  // out_ready: 0 = always ready, 1 = random, otherwise held low.
  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       bus_if.out_ready = 1'b1;
        1:       bus_if.out_ready = ($urandom_range(0, 3) != 0);
        default: bus_if.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each new result.
  initial begin : monitor
    logic        in_txn;
    logic [31:0] held;
    logic [31:0] er;
    int          el;
    int          ac;
    in_txn = 1'b0;
    held   = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 1'b0;
      end else if (bus_if.out_valid) begin
        if (!in_txn) begin
          if (exp_res_q.size() == 0) begin
            check("spurious_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
          end else begin
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            ac = acc_cyc_q.pop_front();
            check("result", bus_if.result, er);
            check("latency", 32'(cyc - ac + 1), 32'(el));
            held   = er;
            in_txn = 1'b1;
          end
        end else begin
          check("result_hold", bus_if.result, held);
        end
        check("in_ready_while_valid", {31'd0, bus_if.in_ready}, 32'd0);
        if (bus_if.out_ready) in_txn = 1'b0;
      end else begin
        in_txn = 1'b0;
      end
    end
  end

  logic [2:0]  d_op[12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                            3'd5, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a[12]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[12]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd2, 32'd2, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int kw;
    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.kill     = 1'b0;
    bus_if.op       = 3'd0;
    bus_if.rs1      = 32'd0;
    bus_if.rs2      = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("reset_result", bus_if.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations including the fast-path cases.
    for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);
    wait_idle();

    // Backpressure: result must hold and in_ready stay low.
    bp_mode = 2;
    @(negedge clk);
    @(negedge clk);
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (N_ITER + 12) @(negedge clk);
    bp_mode = 0;
    wait_idle();

    // Kill in the middle of CALC.
    kw = (N_ITER > 12) ? 12 : N_ITER / 2;
    issue(3'd5, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (kw - 1) @(negedge clk);
    bus_if.kill = 1'b1;
    @(negedge clk);
    bus_if.kill = 1'b0;
    check("kill_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check("kill_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    repeat (N_ITER + 4) @(negedge clk);

    // kill together with in_valid in IDLE: request is dropped.
    bus_if.op       = 3'd0;
    bus_if.rs1      = 32'd3;
    bus_if.rs2      = 32'd4;
    bus_if.in_valid = 1'b1;
    bus_if.kill     = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.kill     = 1'b0;
    check("kill_idle_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Reset in the middle of CALC.
    issue(3'd0, 32'h0000_0101, 32'h0000_0202, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_calc_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check("rst_calc_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_calc_result", bus_if.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Random operations under random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 1000; i++) issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
    bp_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
